// File: rtl/ad_nios_pulse_counter.sv
// Loadable up/down pulse counter on the Nios Avalon bus.
// Counts rising edges of count_in and raises a sticky terminal-count interrupt.
module ad_nios_pulse_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic             count_in,
    output logic             irq
);

    localparam logic [1:0] ADDR_COUNT   = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_RELOAD  = 2'd3;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_readdata;
    logic             r_run;
    logic             r_dir;
    logic             r_ie;
    logic             r_tc;
    logic             r_prev;

    logic             w_wr;
    logic             w_rd;
    logic             w_event;
    logic             w_load;
    logic             w_step;
    logic             w_tc_set;
    logic             w_tc_clr;
    logic [2:0]       w_ctrl_wdata;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_rd_mux;

    assign w_wr         = chipselect & write;
    assign w_rd         = chipselect & read;
    assign w_event      = count_in & ~r_prev & r_run;
    assign w_load       = w_wr && (address == ADDR_COUNT);
    // A COUNT write swallows any event arriving in the same cycle
    assign w_step       = w_event & ~w_load;
    assign w_tc_set     = w_step & (r_dir ? (r_count == '1) : (r_count == '0));
    assign w_tc_clr     = w_wr && (address == ADDR_STATUS) && writedata[0];
    assign w_ctrl_wdata = 3'(writedata);

    assign readdata = r_readdata;
    assign irq      = r_tc & r_ie;

    // Next count: up wraps naturally, down reloads from the old RELOAD at zero
    always_comb begin
        w_count_next = r_count;
        if (w_load) begin
            w_count_next = writedata;
        end else if (w_step) begin
            if (r_dir) begin
                w_count_next = r_count + WIDTH'(1);
            end else if (r_count == '0) begin
                w_count_next = r_reload;
            end else begin
                w_count_next = r_count - WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_COUNT:   w_rd_mux = r_count;
            ADDR_CONTROL: w_rd_mux = WIDTH'({r_ie, r_dir, r_run});
            ADDR_STATUS:  w_rd_mux = WIDTH'(r_tc);
            ADDR_RELOAD:  w_rd_mux = r_reload;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_count    <= '0;
            r_reload   <= '0;
            r_readdata <= '0;
            r_run      <= 1'b0;
            r_dir      <= 1'b0;
            r_ie       <= 1'b0;
            r_tc       <= 1'b0;
            r_prev     <= 1'b0;
        end else begin
            r_prev  <= count_in;
            r_count <= w_count_next;
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
            if (w_wr && (address == ADDR_CONTROL)) begin
                r_run <= w_ctrl_wdata[0];
                r_dir <= w_ctrl_wdata[1];
                r_ie  <= w_ctrl_wdata[2];
            end
            if (w_wr && (address == ADDR_RELOAD)) begin
                r_reload <= writedata;
            end
            // Set beats clear when both land on the same edge
            if (w_tc_set) begin
                r_tc <= 1'b1;
            end else if (w_tc_clr) begin
                r_tc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad_nios_pulse_counter.sv
// Bench for ad_nios_pulse_counter: directed scenarios plus randomized bus/pulse
// traffic, all compared against a cycle-level register model.
module tb_ad_nios_pulse_counter;

    localparam int unsigned WIDTH = 16;
    localparam int MODV = 65536;

    logic             clk = 1'b0;
    logic             sclr = 1'b1;
    logic             chipselect = 1'b0;
    logic [1:0]       address = 2'd0;
    logic             read = 1'b0;
    logic             write = 1'b0;
    logic [WIDTH-1:0] writedata = '0;
    logic [WIDTH-1:0] readdata;
    logic             count_in = 1'b0;
    logic             irq;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the firmware-visible state
    int m_count = 0, m_reload = 0, m_rd = 0;
    bit m_run = 0, m_dir = 0, m_ie = 0, m_tc = 0, m_prev = 0;

    ad_nios_pulse_counter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .sclr       (sclr),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .count_in   (count_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_read(input int a);
        case (a)
            0:       return m_count;
            1:       return int'(m_ie) * 4 + int'(m_dir) * 2 + int'(m_run);
            2:       return int'(m_tc);
            default: return m_reload;
        endcase
    endfunction

    // Advance model and DUT by one clock, then compare visible outputs
    task automatic tick();
        int nc = m_count, nrl = m_reload, nrd = m_rd;
        bit nrun = m_run, ndir = m_dir, nie = m_ie, ntc = m_tc, nprev;
        bit ev, set_tc, wr, rd;
        int wd = int'(writedata);
        wr = chipselect && write;
        rd = chipselect && read;
        if (sclr) begin
            nc = 0; nrl = 0; nrd = 0; nrun = 0; ndir = 0; nie = 0; ntc = 0; nprev = 0;
        end else begin
            ev = count_in && !m_prev && m_run;
            set_tc = 0;
            if (rd) nrd = model_read(int'(address));
            if (wr) begin
                case (address)
                    2'd0: nc = wd;
                    2'd1: begin nrun = wd[0]; ndir = wd[1]; nie = wd[2]; end
                    2'd2: if (wd % 2 == 1) ntc = 0;
                    default: nrl = wd;
                endcase
            end
            if (ev && !(wr && address == 2'd0)) begin
                if (m_dir) begin
                    nc = (m_count + 1) % MODV;
                    set_tc = (m_count + 1 == MODV);
                end else if (m_count == 0) begin
                    nc = m_reload;
                    set_tc = 1;
                end else begin
                    nc = m_count - 1;
                end
            end
            if (set_tc) ntc = 1;
            nprev = count_in;
        end
        @(posedge clk);
        #1;
        m_count = nc; m_reload = nrl; m_rd = nrd;
        m_run = nrun; m_dir = ndir; m_ie = nie; m_tc = ntc; m_prev = nprev;
        check("readdata", 32'(readdata), 32'(m_rd));
        check("irq", 32'(irq), 32'(m_tc & m_ie));
    endtask

    task automatic idle_bus();
        chipselect = 0; read = 0; write = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
        chipselect = 1; write = 1; read = 0; address = a; writedata = d;
        tick();
        idle_bus();
    endtask

    task automatic read_expect(input logic [1:0] a, input int exp, input string tag);
        chipselect = 1; read = 1; write = 0; address = a;
        tick();
        idle_bus();
        check(tag, 32'(readdata), 32'(exp));
    endtask

    task automatic pulse();
        count_in = 1; tick();
        count_in = 0; tick();
    endtask

    initial begin
        // Reset and readback
        sclr = 1; tick(); tick(); sclr = 0;
        for (int a = 0; a < 4; a++) read_expect(2'(a), 0, "reset_read");
        check("reset_irq", 32'(irq), 32'd0);
        bus_write(2'd1, 16'h0007);
        read_expect(2'd1, 16'h0007, "ctrl_readback");

        // Up count through wrap
        bus_write(2'd0, 16'hFFFE);
        for (int i = 0; i < 3; i++) pulse();
        read_expect(2'd0, 16'h0001, "up_wrap_count");
        read_expect(2'd2, 1, "up_wrap_tc");
        check("up_wrap_irq", 32'(irq), 32'd1);
        bus_write(2'd2, 16'h0001);
        check("tc_clear_irq", 32'(irq), 32'd0);

        // Down count with reload
        bus_write(2'd1, 16'h0005);
        bus_write(2'd3, 16'h0005);
        bus_write(2'd0, 16'h0002);
        pulse(); read_expect(2'd0, 1, "down_1");
        read_expect(2'd2, 0, "down_tc_0a");
        pulse(); read_expect(2'd0, 0, "down_0");
        read_expect(2'd2, 0, "down_tc_0b");
        pulse(); read_expect(2'd0, 5, "down_reload");
        read_expect(2'd2, 1, "down_tc_1");
        bus_write(2'd2, 16'h0001);

        // COUNT write collides with an event
        count_in = 1;
        bus_write(2'd0, 16'h1234);
        count_in = 0; tick();
        read_expect(2'd0, 16'h1234, "load_beats_event");

        // TC clear collides with a wrap
        bus_write(2'd1, 16'h0007);
        bus_write(2'd0, 16'hFFFF);
        count_in = 1;
        bus_write(2'd2, 16'h0001);
        count_in = 0; tick();
        read_expect(2'd2, 1, "set_beats_clear");
        read_expect(2'd0, 0, "wrap_count");

        // Constant-high input gives a single event
        bus_write(2'd2, 16'h0001);
        bus_write(2'd0, 16'h0010);
        count_in = 1;
        for (int i = 0; i < 10; i++) tick();
        count_in = 0; tick();
        read_expect(2'd0, 16'h0011, "held_high");

        // RUN=0 gates events
        bus_write(2'd1, 16'h0006);
        for (int i = 0; i < 4; i++) pulse();
        read_expect(2'd0, 16'h0011, "run_gated");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int pick;
            sclr = ($urandom_range(199, 0) == 0);
            chipselect = $urandom_range(1, 0);
            read = $urandom_range(1, 0);
            write = ($urandom_range(3, 0) == 0);
            address = 2'($urandom_range(3, 0));
            pick = $urandom_range(7, 0);
            case (pick)
                0: writedata = 16'hFFFF;
                1: writedata = 16'hFFFE;
                2: writedata = 16'h0000;
                3: writedata = 16'h0001;
                4: writedata = 16'h0007;
                default: writedata = 16'($urandom);
            endcase
            count_in = $urandom_range(1, 0);
            tick();
        end
        sclr = 0; idle_bus(); count_in = 0; tick();

        // Reset in the middle of activity
        bus_write(2'd1, 16'h0007);
        bus_write(2'd3, 16'h00AA);
        bus_write(2'd0, 16'hFFFF);
        pulse();
        check("pre_reset_irq", 32'(irq), 32'd1);
        chipselect = 1; read = 1; address = 2'd0; count_in = 1; sclr = 1;
        tick();
        sclr = 0; idle_bus(); count_in = 0;
        check("reset_mid_readdata", 32'(readdata), 32'd0);
        check("reset_mid_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) read_expect(2'(a), 0, "reset_mid_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
